// File: rtl/adder_operand_loader_if.sv
// ============================================================================
//  Module      : adder_operand_loader_if
//  Description : Stream-in / operand-pair-out bundle for adder_operand_loader.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface adder_operand_loader_if #(
    parameter int N = 34,
    parameter int W = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         op_valid;
    logic         op_ready;
    logic [N-1:0] op_x;
    logic [N-1:0] op_y;
    logic         trunc_err;

    modport master (
        output in_valid, in_data, op_ready,
        input  in_ready, op_valid, op_x, op_y, trunc_err
    );

    modport slave (
        input  in_valid, in_data, op_ready,
        output in_ready, op_valid, op_x, op_y, trunc_err
    );
endinterface

`default_nettype wire

// File: rtl/adder_operand_loader.sv
// ============================================================================
//  Module      : adder_operand_loader
//  Description : Deserializes a little-endian word stream into operands x, y
//                and holds them as a pair under valid/ready. Optional macro
//                ADDER_LOADER_TRUNC_CHECK_EN enables the sticky trunc_err.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module adder_operand_loader #(
    parameter int N = 34,
    parameter int W = 8
) (
    input  wire logic             clk,
    input  wire logic             rst,
    adder_operand_loader_if.slave bus
);

    localparam int c_k     = (N + W - 1) / W;
    localparam int c_cnt_w = (c_k > 1) ? $clog2(c_k) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(c_k - 1);

    typedef enum logic [1:0] {
        S_LOAD_X = 2'd0,
        S_LOAD_Y = 2'd1,
        S_HOLD   = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [c_cnt_w-1:0]   cnt_q, cnt_d;
    logic [N-1:0]         op_x_q, op_x_d;
    logic [N-1:0]         op_y_q, op_y_d;
    logic                 w_xfer;
    logic                 w_last;

    // Write one word into its slot; the widened copy absorbs bits at or above N.
    function automatic logic [N-1:0] f_insert(
        input logic [N-1:0]       op,
        input logic [c_cnt_w-1:0] idx,
        input logic [W-1:0]       d
    );
        logic [c_k*W-1:0] wide;
        wide                      = '0;
        wide[N-1:0]               = op;
        wide[int'(idx)*W +: W]    = d;
        return wide[N-1:0];
    endfunction

    assign w_xfer = bus.in_valid && (state_q != S_HOLD);
    assign w_last = (cnt_q == c_last);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_x_d  = op_x_q;
        op_y_d  = op_y_q;
        unique case (state_q)
            S_LOAD_X: begin
                if (bus.in_valid) begin
                    op_x_d = f_insert(op_x_q, cnt_q, bus.in_data);
                    cnt_d  = w_last ? '0 : cnt_q + 1'b1;
                    if (w_last) state_d = S_LOAD_Y;
                end
            end
            S_LOAD_Y: begin
                if (bus.in_valid) begin
                    op_y_d = f_insert(op_y_q, cnt_q, bus.in_data);
                    cnt_d  = w_last ? '0 : cnt_q + 1'b1;
                    if (w_last) state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (bus.op_ready) state_d = S_LOAD_X;
            end
            default: begin
                state_d = S_LOAD_X;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_LOAD_X;
            cnt_q   <= '0;
            op_x_q  <= '0;
            op_y_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_x_q  <= op_x_d;
            op_y_q  <= op_y_d;
        end
    end

    // Handshake outputs come from registered state only.
    assign bus.in_ready = (state_q != S_HOLD);
    assign bus.op_valid = (state_q == S_HOLD);
    assign bus.op_x     = op_x_q;
    assign bus.op_y     = op_y_q;

`ifdef ADDER_LOADER_TRUNC_CHECK_EN
    localparam int c_drop_lsb = N - (c_k - 1) * W;

    logic w_trunc_hit;
    logic trunc_q, trunc_d;

    generate
        if (c_drop_lsb < W) begin : g_trunc_check
            assign w_trunc_hit = w_xfer && w_last && (|bus.in_data[W-1:c_drop_lsb]);
        end else begin : g_no_drop
            assign w_trunc_hit = 1'b0;
        end
    endgenerate

    always_comb begin
        trunc_d = trunc_q | w_trunc_hit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            trunc_q <= 1'b0;
        end else begin
            trunc_q <= trunc_d;
        end
    end

    assign bus.trunc_err = trunc_q;
`else
    assign bus.trunc_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_adder_operand_loader.sv
// ============================================================================
//  Module      : tb_adder_operand_loader
//  Description : Scoreboard bench for adder_operand_loader (N=34 and N=16).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adder_operand_loader;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

`ifdef ADDER_LOADER_TRUNC_CHECK_EN
    localparam logic c_exp_trunc = 1'b1;
`else
    localparam logic c_exp_trunc = 1'b0;
`endif

    adder_operand_loader_if #(.N(34), .W(8)) bus34 ();
    adder_operand_loader_if #(.N(16), .W(8)) bus16 ();

    adder_operand_loader #(.N(34), .W(8)) u_dut34 (.clk(clk), .rst(rst), .bus(bus34));
    adder_operand_loader #(.N(16), .W(8)) u_dut16 (.clk(clk), .rst(rst), .bus(bus16));

    int checks   = 0;
    int failures = 0;

    logic [67:0] sb_q[$];
    logic        prev_valid = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pops one expected pair on every rising edge of op_valid.
    always @(negedge clk) begin
        logic [67:0] e;
        logic [34:0] exp_sum;
        logic [34:0] obs_sum;
        if (bus34.op_valid && !prev_valid) begin
            if (sb_q.size() != 0) begin
                e       = sb_q.pop_front();
                exp_sum = {1'b0, e[67:34]} + {1'b0, e[33:0]};
                obs_sum = {1'b0, bus34.op_x} + {1'b0, bus34.op_y};
                check_eq("sb_op_x", bus34.op_x, e[67:34]);
                check_eq("sb_op_y", bus34.op_y, e[33:0]);
                check_eq("sb_adder", obs_sum, exp_sum);
            end else begin
                check_eq("sb_depth", sb_q.size(), 1);
            end
        end
        prev_valid = bus34.op_valid;
    end

    // Called at a negedge; returns at the negedge after the word transferred.
    task automatic send_word(input logic [7:0] w, input int gap);
        int n;
        bus34.in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        bus34.in_valid = 1'b1;
        bus34.in_data  = w;
        n = 0;
        while (!bus34.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check_eq("in_ready_wait", bus34.in_ready, 1);
        @(negedge clk);
        bus34.in_valid = 1'b0;
    endtask

    // stream[39:0] holds the five x words, stream[79:40] the five y words.
    task automatic send_pair(input logic [79:0] stream, input int max_gap);
        sb_q.push_back({stream[33:0], stream[73:40]});
        for (int i = 0; i < 10; i++) begin
            send_word(stream[8*i +: 8], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
        end
    endtask

    task automatic send_word16(input logic [7:0] w);
        int n;
        bus16.in_valid = 1'b1;
        bus16.in_data  = w;
        n = 0;
        while (!bus16.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check_eq("in_ready16_wait", bus16.in_ready, 1);
        @(negedge clk);
        bus16.in_valid = 1'b0;
    endtask

    initial begin
        bus34.in_valid = 1'b0;
        bus34.in_data  = '0;
        bus34.op_ready = 1'b1;
        bus16.in_valid = 1'b0;
        bus16.in_data  = '0;
        bus16.op_ready = 1'b1;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_eq("rst_in_ready", bus34.in_ready, 1);
        check_eq("rst_op_valid", bus34.op_valid, 0);
        check_eq("rst_op_x", bus34.op_x, 0);
        check_eq("rst_op_y", bus34.op_y, 0);
        check_eq("rst_trunc", bus34.trunc_err, 0);

        // Pair A: all-ones x plus one wraps to zero with carry out.
        send_pair({40'h00_0000_0001, 40'h03_FFFF_FFFF}, 0);
        check_eq("a_op_valid", bus34.op_valid, 1);
        check_eq("a_in_ready", bus34.in_ready, 0);
        check_eq("a_adder", {1'b0, bus34.op_x} + {1'b0, bus34.op_y}, 35'h4_0000_0000);
        @(negedge clk);
        check_eq("a_op_valid_fall", bus34.op_valid, 0);
        check_eq("a_in_ready_rise", bus34.in_ready, 1);
        check_eq("a_trunc", bus34.trunc_err, 0);

        // Pair B: same stream with random idle gaps.
        send_pair({40'h00_0000_0001, 40'h03_FFFF_FFFF}, 5);
        check_eq("b_op_valid", bus34.op_valid, 1);
        @(negedge clk);

        // Pair C: backpressure in HOLD while in_valid stays high.
        bus34.op_ready = 1'b0;
        send_pair({40'h01_89AB_CDEF, 40'h02_1234_5678}, 0);
        for (int i = 0; i < 10; i++) begin
            bus34.in_valid = 1'b1;
            bus34.in_data  = 8'($urandom);
            @(negedge clk);
            check_eq("bp_in_ready", bus34.in_ready, 0);
            check_eq("bp_op_valid", bus34.op_valid, 1);
            check_eq("bp_op_x", bus34.op_x, 34'h2_1234_5678);
            check_eq("bp_op_y", bus34.op_y, 34'h1_89AB_CDEF);
        end
        bus34.op_ready = 1'b1;
        @(negedge clk);
        bus34.in_valid = 1'b0;
        check_eq("bp_in_ready_rise", bus34.in_ready, 1);
        check_eq("bp_op_valid_fall", bus34.op_valid, 0);
        send_pair({40'h00_0000_0005, 40'h00_0000_0007}, 2);
        @(negedge clk);

        // Truncation: last x word carries non-zero dropped bits.
        send_pair({40'h00_0000_0000, 40'hFF_FFFF_FFFF}, 0);
        check_eq("tr_trunc", bus34.trunc_err, c_exp_trunc);
        @(negedge clk);
        send_pair({40'h00_0000_0002, 40'h00_0000_0003}, 1);
        check_eq("tr_sticky", bus34.trunc_err, c_exp_trunc);
        @(negedge clk);

        // Reset mid-load discards the partial pair.
        send_word(8'hFF, 0);
        send_word(8'hFF, 0);
        send_word(8'hFF, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("mr_op_x", bus34.op_x, 0);
        check_eq("mr_op_y", bus34.op_y, 0);
        check_eq("mr_op_valid", bus34.op_valid, 0);
        check_eq("mr_in_ready", bus34.in_ready, 1);
        check_eq("mr_trunc", bus34.trunc_err, 0);
        send_pair({40'h00_8877_6655, 40'h01_4433_2211}, 0);
        check_eq("mr_op_valid_hold", bus34.op_valid, 1);
        @(negedge clk);

        // N=16 instance: exact multiple of W, no truncation possible.
        send_word16(8'h34);
        send_word16(8'h12);
        send_word16(8'h78);
        send_word16(8'h56);
        check_eq("n16_op_valid", bus16.op_valid, 1);
        check_eq("n16_op_x", bus16.op_x, 16'h1234);
        check_eq("n16_op_y", bus16.op_y, 16'h5678);
        check_eq("n16_adder", {1'b0, bus16.op_x} + {1'b0, bus16.op_y}, 17'h0_68AC);
        check_eq("n16_trunc", bus16.trunc_err, 0);
        @(negedge clk);
        check_eq("n16_op_valid_fall", bus16.op_valid, 0);

        repeat (2) @(negedge clk);
        check_eq("sb_drained", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
